// File: rtl/sdrc_req_arbiter.sv
// sdrc_req_arbiter
//   Round-robin arbiter that shares the single SDRAM controller application request
//   port among N_REQ requesters. One requester is granted, its command is latched and
//   forwarded, and the grant is held until the controller reports the matching last
//   beat. Priority then rotates to the slot after the owner.
//
// Optional feature macro: SDRC_ARB_TIMEOUT_EN
//   When defined, a watchdog aborts a transfer that has not completed within
//   TIMEOUT_CYC cycles of its grant and pulses timeout_err_o. When undefined, no
//   counter is built and timeout_err_o is tied low.
//
// Ports
//   wb_clk_i, wb_rst_i          clock and asynchronous active-high reset
//   req_i / req_addr_i /
//   req_len_i / req_wr_n_i      per-requester command inputs (packed per slot)
//   gnt_o                       one-hot grant, held for the whole transfer
//   ack_o                       1-cycle pulse to the owner when the controller accepts
//   app_req_o, app_req_*_o      latched command towards the controller
//   app_req_ack_i               controller accepted the command
//   app_last_wr_i/app_last_rd_i last write / read beat
//   busy_o                      arbiter is not idle
//   owner_o                     index of the current (or last) owner
//   timeout_err_o               1-cycle pulse on a watchdog abort
module sdrc_req_arbiter #(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned APP_AW      = 26,
    parameter int unsigned APP_RW      = 9,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_i,
    input  logic [N_REQ-1:0]           req_i,
    input  logic [N_REQ*APP_AW-1:0]    req_addr_i,
    input  logic [N_REQ*APP_RW-1:0]    req_len_i,
    input  logic [N_REQ-1:0]           req_wr_n_i,
    output logic [N_REQ-1:0]           gnt_o,
    output logic [N_REQ-1:0]           ack_o,
    output logic                       app_req_o,
    output logic [APP_AW-1:0]          app_req_addr_o,
    output logic [APP_RW-1:0]          app_req_len_o,
    output logic                       app_req_wr_n_o,
    input  logic                       app_req_ack_i,
    input  logic                       app_last_wr_i,
    input  logic                       app_last_rd_i,
    output logic                       busy_o,
    output logic [$clog2(N_REQ)-1:0]   owner_o,
    output logic                       timeout_err_o
);

    localparam int unsigned OW = $clog2(N_REQ);

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("sdrc_req_arbiter: unsupported N_REQ or TIMEOUT_CYC");
    end

    typedef enum logic [1:0] {StIdle, StIssue, StData} state_e;

    state_e            state_q, state_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [N_REQ-1:0]  ack_q, ack_d;
    logic              app_req_q, app_req_d;
    logic [APP_AW-1:0] addr_q, addr_d;
    logic [APP_RW-1:0] len_q, len_d;
    logic              wr_n_q, wr_n_d;
    logic [OW-1:0]     owner_q, owner_d;
    logic [OW-1:0]     rr_ptr_q, rr_ptr_d;
    logic              tmo_q, tmo_d;

    logic [APP_AW-1:0] addr_arr [N_REQ];
    logic [APP_RW-1:0] len_arr  [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign addr_arr[i] = req_addr_i[i*APP_AW +: APP_AW];
        assign len_arr[i]  = req_len_i[i*APP_RW +: APP_RW];
    end

    // Round-robin scan starting at rr_ptr; the first set request wins.
    logic          win_valid;
    logic [OW-1:0] win_idx;
    logic [OW-1:0] scan_idx;

    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        scan_idx  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            scan_idx = OW'((int'(rr_ptr_q) + k) % N_REQ);
            if (!win_valid && req_i[scan_idx]) begin
                win_valid = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    // Only the last beat matching the owner's direction completes a transfer.
    logic          last_match;
    logic [OW-1:0] next_ptr;

    assign last_match = wr_n_q ? app_last_rd_i : app_last_wr_i;
    assign next_ptr   = (owner_q == OW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;

    logic cnt_hit;

`ifdef SDRC_ARB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);
    logic [CntW-1:0] cnt_q, cnt_d;

    // Held at zero while idle so it starts from zero at every grant.
    always_comb begin
        cnt_d = '0;
        if (state_q != StIdle) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The edge taken while cnt_q is TIMEOUT_CYC-1 is the TIMEOUT_CYC-th busy cycle.
    assign cnt_hit = (cnt_q == CntW'(TIMEOUT_CYC - 1));
`else
    assign cnt_hit = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        ack_d     = '0;
        app_req_d = app_req_q;
        addr_d    = addr_q;
        len_d     = len_q;
        wr_n_d    = wr_n_q;
        owner_d   = owner_q;
        rr_ptr_d  = rr_ptr_q;
        tmo_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (win_valid) begin
                    state_d        = StIssue;
                    app_req_d      = 1'b1;
                    gnt_d          = '0;
                    gnt_d[win_idx] = 1'b1;
                    owner_d        = win_idx;
                    addr_d         = addr_arr[win_idx];
                    len_d          = len_arr[win_idx];
                    wr_n_d         = req_wr_n_i[win_idx];
                end
            end
            StIssue: begin
                if (app_req_ack_i) begin
                    app_req_d      = 1'b0;
                    ack_d[owner_q] = 1'b1;
                end
                if (app_req_ack_i && last_match) begin
                    state_d  = StIdle;
                    gnt_d    = '0;
                    rr_ptr_d = next_ptr;
                end else if (cnt_hit) begin
                    state_d   = StIdle;
                    gnt_d     = '0;
                    app_req_d = 1'b0;
                    rr_ptr_d  = next_ptr;
                    tmo_d     = 1'b1;
                end else if (app_req_ack_i) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (last_match) begin
                    state_d  = StIdle;
                    gnt_d    = '0;
                    rr_ptr_d = next_ptr;
                end else if (cnt_hit) begin
                    state_d  = StIdle;
                    gnt_d    = '0;
                    rr_ptr_d = next_ptr;
                    tmo_d    = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q   <= StIdle;
            gnt_q     <= '0;
            ack_q     <= '0;
            app_req_q <= 1'b0;
            addr_q    <= '0;
            len_q     <= '0;
            wr_n_q    <= 1'b0;
            owner_q   <= '0;
            rr_ptr_q  <= '0;
            tmo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            ack_q     <= ack_d;
            app_req_q <= app_req_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            wr_n_q    <= wr_n_d;
            owner_q   <= owner_d;
            rr_ptr_q  <= rr_ptr_d;
            tmo_q     <= tmo_d;
        end
    end

    assign gnt_o          = gnt_q;
    assign ack_o          = ack_q;
    assign app_req_o      = app_req_q;
    assign app_req_addr_o = addr_q;
    assign app_req_len_o  = len_q;
    assign app_req_wr_n_o = wr_n_q;
    assign busy_o         = (state_q != StIdle);
    assign owner_o        = owner_q;
    assign timeout_err_o  = tmo_q;

endmodule
